// File: rtl/vga_rx_monitor.sv
// rtl/vga_rx_monitor.sv - VGA receive-side timing checker, lock tracker and pixel capture
// Optional feature macro: VGA_RX_CHECKSUM_EN (adds frameSum, a per-frame rotating-XOR checksum).
module vga_rx_monitor #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int LOCK_FRAMES     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixelEnable,
  input  logic        hSync,
  input  logic        vSync,
  input  logic [7:0]  rgb,
  output logic        locked,
  output logic        pixelValid,
  output logic [9:0]  xPos,
  output logic [9:0]  yPos,
  output logic [7:0]  pixel,
  output logic        frameDone,
  output logic [7:0]  errCount
`ifdef VGA_RX_CHECKSUM_EN
  ,
  output logic [15:0] frameSum
`endif
);

  localparam int         H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int         V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] H_START  = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_END    = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
  localparam logic [9:0] V_START  = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_END    = 10'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
  localparam logic [9:0] CNT_MAX  = 10'h3FF;
  localparam logic [3:0] LOCK_N   = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} stateType;

  stateType   state, stateNext;
  logic [3:0] goodFrames, goodNext;
  logic       hsPrev, vsPrev, hRef, vRef;
  logic [9:0] hCnt, vCnt, hsWidth, vsWidth;
  logic [9:0] hCntNext, vCntNext;
  logic       hs, vs, hEdge, vEdge, hErr, vErr, anyErr;
  logic       colActive, rowActive;
  logic       pixelValidNext, frameDoneNext, errInc;

  assign hs    = SYNC_ACTIVE_LOW ? ~hSync : hSync;
  assign vs    = SYNC_ACTIVE_LOW ? ~vSync : vSync;
  assign hEdge = hs & ~hsPrev;
  // vertical sync is only looked at on line starts, so vEdge is line-granular
  assign vEdge = hEdge & vs & ~vsPrev;

  assign hCntNext = hEdge ? 10'd0 : ((hCnt == CNT_MAX) ? hCnt : hCnt + 10'd1);
  assign vCntNext = vEdge ? 10'd0 :
                    ((hEdge && (vCnt != CNT_MAX)) ? vCnt + 10'd1 : vCnt);

  // hCnt about to hit 1023 means the line never got its sync
  assign hErr = (hEdge & hRef & ((hCnt != H_LAST) | (hsWidth != H_SYNC_W))) |
                (~hEdge & (hCnt == CNT_MAX - 10'd1));
  assign vErr = vEdge & vRef & ((vCnt != V_LAST) | (vsWidth != V_SYNC_W));
  assign anyErr = hErr | vErr;

  assign colActive = (hCntNext >= H_START) && (hCntNext < H_END);
  assign rowActive = (vCntNext >= V_START) && (vCntNext < V_END);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SEARCH;
      goodFrames <= 4'd0;
      locked     <= 1'b0;
    end else begin
      state      <= stateNext;
      goodFrames <= goodNext;
      locked     <= (stateNext == LOCKED);
    end
  end

  always_comb begin
    stateNext      = state;
    goodNext       = goodFrames;
    errInc         = 1'b0;
    frameDoneNext  = 1'b0;
    pixelValidNext = 1'b0;
    if (pixelEnable) begin
      pixelValidNext = (state == LOCKED) && colActive && rowActive;
      case (state)
        SEARCH: begin
          if (vEdge) begin
            stateNext = ACQUIRE;
            goodNext  = 4'd0;
          end
        end
        ACQUIRE: begin
          if (anyErr) begin
            stateNext = SEARCH;
            errInc    = 1'b1;
          end else if (vEdge) begin
            goodNext = goodFrames + 4'd1;
            if (goodNext == LOCK_N) begin
              stateNext     = LOCKED;
              frameDoneNext = 1'b1;
            end
          end
        end
        LOCKED: begin
          if (anyErr) begin
            stateNext = SEARCH;
            errInc    = 1'b1;
          end else if (vEdge) begin
            frameDoneNext = 1'b1;
          end
        end
        default: stateNext = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hsPrev     <= 1'b0;
      vsPrev     <= 1'b0;
      hRef       <= 1'b0;
      vRef       <= 1'b0;
      hCnt       <= 10'd0;
      vCnt       <= 10'd0;
      hsWidth    <= 10'd0;
      vsWidth    <= 10'd0;
      pixelValid <= 1'b0;
      frameDone  <= 1'b0;
      xPos       <= 10'd0;
      yPos       <= 10'd0;
      pixel      <= 8'd0;
      errCount   <= 8'd0;
    end else begin
      pixelValid <= pixelValidNext;
      frameDone  <= frameDoneNext;
      if (pixelEnable) begin
        hsPrev <= hs;
        hCnt   <= hCntNext;
        vCnt   <= vCntNext;
        if (hEdge) begin
          vsPrev <= vs;
          hRef   <= 1'b1;
        end
        if (vEdge) vRef <= 1'b1;
        if (hEdge) hsWidth <= 10'd1;
        else if (hs && hsPrev && (hsWidth != CNT_MAX)) hsWidth <= hsWidth + 10'd1;
        if (vEdge) vsWidth <= 10'd1;
        else if (hEdge && vs && vsPrev && (vsWidth != CNT_MAX)) vsWidth <= vsWidth + 10'd1;
        if (pixelValidNext) begin
          xPos  <= hCntNext - H_START;
          yPos  <= vCntNext - V_START;
          pixel <= rgb;
        end
        if (errInc && (errCount != 8'hFF)) errCount <= errCount + 8'd1;
      end
    end
  end

`ifdef VGA_RX_CHECKSUM_EN
  logic [15:0] acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= 16'd0;
      frameSum <= 16'd0;
    end else if (pixelEnable) begin
      if (vEdge) begin
        if (frameDoneNext) frameSum <= acc;
        acc <= 16'd0;
      end else if (pixelValidNext) begin
        acc <= {acc[14:0], acc[15]} ^ {8'h00, rgb};
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb/tb_vga_rx_monitor.sv - randomized line/frame stimulus against a line-level reference model
// Uses a shrunken 15x9 raster so full frames are cheap; VGA_RX_CHECKSUM_EN also checks frameSum.
module tb_vga_rx_monitor;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2, HT = HA + HF + HS + HB;
  localparam int VA = 4, VF = 1, VS = 2, VB = 2, VT = VA + VF + VS + VB;
  localparam int LOCKF = 2;
  localparam bit SAL = 1'b1;

  logic       clk = 1'b0;
  logic       reset, pixelEnable, hSync, vSync;
  logic [7:0] rgb;
  logic       locked, pixelValid, frameDone;
  logic [9:0] xPos, yPos;
  logic [7:0] pixel, errCount;
`ifdef VGA_RX_CHECKSUM_EN
  logic [15:0] frameSum;
`endif

  always #5 clk = ~clk;

  vga_rx_monitor #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE_LOW(SAL), .LOCK_FRAMES(LOCKF)
  ) dut (
    .clk(clk), .reset(reset), .pixelEnable(pixelEnable), .hSync(hSync), .vSync(vSync),
    .rgb(rgb), .locked(locked), .pixelValid(pixelValid), .xPos(xPos), .yPos(yPos),
    .pixel(pixel), .frameDone(frameDone), .errCount(errCount)
`ifdef VGA_RX_CHECKSUM_EN
    , .frameSum(frameSum)
`endif
  );

  int nChecks = 0, nFails = 0;
  bit done = 0;

  // expected outputs after the next active clock edge
  bit eLocked, ePv, eFd;
  int eX, eY, ePix, eErr, eSum;

  // line-level reference state: 0 search, 1 acquire, 2 locked
  int mState, mGood, prevLen, prevHsw, linesSinceV, vRun, mAcc;
  bit hRef, vRef, prevVs, inRun;

  int pvCount, firstX, firstY, lastX, lastY;
  bit firstSeen;

  task automatic check(string name, int act, int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void modelReset();
    mState = 0; mGood = 0; prevLen = 0; prevHsw = 0; linesSinceV = 0; vRun = 0; mAcc = 0;
    hRef = 0; vRef = 0; prevVs = 0; inRun = 0;
    eLocked = 0; ePv = 0; eFd = 0; eX = 0; eY = 0; ePix = 0; eErr = 0; eSum = 0;
  endfunction

  // one pixelEnable sample at offset 'off' of a line described by (len, hsw, vsLine)
  function automatic void modelSample(int off, int len, int hsw, bit vsLine, int c);
    bit err = 0;
    bit isV = 0;
    int st = mState;
    int col, row;
    ePv = 0;
    eFd = 0;
    if (off == 0) begin
      if (hRef && (prevLen != HT || prevHsw != HS)) err = 1;
      hRef = 1; prevLen = len; prevHsw = hsw;
      isV = vsLine && !prevVs;
      if (isV) begin
        if (vRef && (linesSinceV != VT || vRun != VS)) err = 1;
        vRef = 1; linesSinceV = 1; vRun = 1; inRun = 1;
      end else begin
        linesSinceV++;
        if (inRun && vsLine) vRun++;
        else inRun = 0;
      end
      prevVs = vsLine;
    end else if (off == 1023) begin
      err = 1;
    end
    col = off - (HS + HB);
    row = linesSinceV - 1 - (VS + VB);
    if (st == 2 && col >= 0 && col < HA && row >= 0 && row < VA) begin
      ePv = 1; eX = col; eY = row; ePix = c;
      mAcc = ((((mAcc << 1) & 'hFFFF) | ((mAcc >> 15) & 1)) ^ c);
    end
    if (st != 0 && err) begin
      if (eErr < 255) eErr++;
      mState = 0;
    end else if (isV) begin
      if (st == 0) begin
        mState = 1; mGood = 0;
      end else if (st == 1) begin
        mGood++;
        if (mGood == LOCKF) begin mState = 2; eFd = 1; end
      end else begin
        eFd = 1;
      end
    end
    eLocked = (mState == 2);
    if (isV) begin
      if (eFd) eSum = mAcc;
      mAcc = 0;
    end
  endfunction

  initial begin
    @(negedge clk);
    while (!done) begin
      @(posedge clk);
      #2;
      check("locked", locked, eLocked);
      check("pixelValid", pixelValid, ePv);
      check("frameDone", frameDone, eFd);
      check("errCount", errCount, eErr);
`ifdef VGA_RX_CHECKSUM_EN
      check("frameSum", frameSum, eSum);
`endif
      if (ePv) begin
        check("xPos", xPos, eX);
        check("yPos", yPos, eY);
        check("pixel", pixel, ePix);
      end
      if (pixelValid) begin
        pvCount++;
        if (!firstSeen) begin firstSeen = 1; firstX = xPos; firstY = yPos; end
        lastX = xPos; lastY = yPos;
      end
    end
  end

  task automatic idle();
    int n = $urandom_range(0, 2);
    repeat (n) begin
      @(negedge clk);
      reset = 0; pixelEnable = 0;
      hSync = 1'($urandom); vSync = 1'($urandom); rgb = 8'($urandom);
      ePv = 0; eFd = 0;
    end
  endtask

  task automatic doReset(int n);
    repeat (n) begin
      @(negedge clk);
      reset = 1; pixelEnable = 1'($urandom);
      hSync = 1'($urandom); vSync = 1'($urandom); rgb = 8'($urandom);
      modelReset();
    end
  endtask

  task automatic sendLine(int len, int hsw, bit vsLine, int startOff = 0, int endOff = -1);
    int stop = (endOff < 0) ? len : endOff;
    for (int off = startOff; off < stop; off++) begin
      idle();
      @(negedge clk);
      reset = 0; pixelEnable = 1;
      hSync = (off < hsw) ? ~SAL : SAL;
      vSync = (off == 0) ? (vsLine ? ~SAL : SAL) : 1'($urandom);
      rgb = 8'($urandom);
      modelSample(off, len, hsw, vsLine, int'(rgb));
    end
  endtask

  task automatic sendFrame(int vsw = VS, int nLines = VT, int badLine = -1,
                           int badLen = HT, int badHsw = HS);
    for (int l = 0; l < nLines; l++)
      sendLine((l == badLine) ? badLen : HT, (l == badLine) ? badHsw : HS, l < vsw);
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  initial begin
    reset = 1; pixelEnable = 0; hSync = SAL; vSync = SAL; rgb = 8'd0;
    modelReset();
    doReset(2);
    settle();
    check("reset_locked", locked, 0);
    check("reset_errCount", errCount, 0);

    sendFrame();
    sendFrame();
    settle();
    check("not_locked_after_2_vedges", locked, 0);
    sendFrame();
    settle();
    check("locked_after_3_vedges", locked, 1);
    check("no_errors_ideal", errCount, 0);

    pvCount = 0; firstSeen = 0;
    sendFrame();
    settle();
    check("pixels_per_frame", pvCount, HA * VA);
    check("first_x", firstX, 0);
    check("first_y", firstY, 0);
    check("last_x", lastX, HA - 1);
    check("last_y", lastY, VA - 1);

    sendFrame(VS, VT, 5, HT - 1, HS);
    settle();
    check("short_line_err", errCount, 1);
    check("short_line_unlock", locked, 0);
    sendFrame();
    sendFrame();
    settle();
    check("short_line_still_acq", locked, 0);
    sendFrame();
    settle();
    check("short_line_relock", locked, 1);

    sendFrame(VS, VT, 2, HT, HS - 1);
    repeat (3) sendFrame();
    settle();
    check("hsync_width_err", errCount, 2);
    sendFrame(3);
    settle();
    check("vsync_width_pending", errCount, 2);
    sendFrame();
    settle();
    check("vsync_width_err", errCount, 3);
    repeat (3) sendFrame();

    sendFrame(VS, VT, 6, 1030, HS);
    settle();
    check("missing_hsync_err", errCount, 4);
    repeat (3) sendFrame();
    settle();
    check("missing_hsync_relock", locked, 1);

    for (int l = 0; l < 6; l++) sendLine(HT, HS, l < VS);
    sendLine(HT, HS, 0, 0, 9);
    doReset(3);
    settle();
    check("midframe_reset_locked", locked, 0);
    check("midframe_reset_pv", pixelValid, 0);
    check("midframe_reset_err", errCount, 0);
    check("midframe_reset_x", xPos, 0);
    pvCount = 0;
    sendLine(HT, HS, 0, 9);
    sendLine(HT, HS, 0);
    sendLine(HT, HS, 0);
    sendFrame();
    sendFrame();
    settle();
    check("no_pixels_before_relock", pvCount, 0);
    sendFrame();

    for (int f = 0; f < 12; f++) begin
      int kind = $urandom_range(0, 6);
      case (kind)
        3: sendFrame(VS, VT, $urandom_range(0, VT - 1), ($urandom_range(0, 1) != 0) ? HT + 1 : HT - 1, HS);
        4: sendFrame(VS, VT, $urandom_range(0, VT - 1), HT, ($urandom_range(0, 1) != 0) ? HS + 1 : HS - 1);
        5: sendFrame(($urandom_range(0, 1) != 0) ? VS + 1 : VS - 1);
        6: sendFrame(VS, ($urandom_range(0, 1) != 0) ? VT + 1 : VT - 1);
        default: sendFrame();
      endcase
    end

    for (int i = 0; i < 300; i++) begin
      sendLine(6, 3, 1);
      sendLine(6, 3, 0);
    end
    settle();
    check("errCount_saturates", errCount, 255);
    doReset(2);
    settle();
    check("errCount_cleared_by_reset", errCount, 0);

    done = 1;
    settle();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
